axi4l_wb_bridge_dec: RTL and testbench

//  AXI4-Lite slave to Wishbone B3 classic master bridge with a built-in N-way address decoder.

---
 rtl/axi4l_wb_bridge_dec_if.sv | 54 +++++
 rtl/axi4l_wb_bridge_dec.sv | 172 +++++++++++++++++
 tb/tb_axi4l_wb_bridge_dec.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4l_wb_bridge_dec_if.sv
// Bus bundle for the AXI4-Lite to Wishbone decoding bridge: AXI4-Lite slave side plus
// the shared/per-target Wishbone master side.
interface axi4l_wb_bridge_dec_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NR_SLAVES  = 3
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0]           s_aw_addr;
  logic                            s_aw_valid;
  logic                            s_aw_ready;
  logic [DATA_WIDTH-1:0]           s_w_data;
  logic [STRB_W-1:0]               s_w_strb;
  logic                            s_w_valid;
  logic                            s_w_ready;
  logic [1:0]                      s_b_resp;
  logic                            s_b_valid;
  logic                            s_b_ready;
  logic [ADDR_WIDTH-1:0]           s_ar_addr;
  logic                            s_ar_valid;
  logic                            s_ar_ready;
  logic [DATA_WIDTH-1:0]           s_r_data;
  logic [1:0]                      s_r_resp;
  logic                            s_r_valid;
  logic                            s_r_ready;
  logic [ADDR_WIDTH-1:0]           wb_adr_o;
  logic [DATA_WIDTH-1:0]           wb_dat_o;
  logic [STRB_W-1:0]               wb_sel_o;
  logic                            wb_we_o;
  logic [NR_SLAVES-1:0]            wb_cyc_o;
  logic [NR_SLAVES-1:0]            wb_stb_o;
  logic [NR_SLAVES*DATA_WIDTH-1:0] wb_dat_i;
  logic [NR_SLAVES-1:0]            wb_ack_i;
  logic [NR_SLAVES-1:0]            wb_err_i;

  // Bridge view: AXI4-Lite slave, Wishbone master.
  modport slave (
    input  s_aw_addr, s_aw_valid, s_w_data, s_w_strb, s_w_valid, s_b_ready,
    input  s_ar_addr, s_ar_valid, s_r_ready,
    output s_aw_ready, s_w_ready, s_b_resp, s_b_valid, s_ar_ready, s_r_data, s_r_resp, s_r_valid,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  // Environment view: AXI4-Lite master, Wishbone targets.
  modport master (
    output s_aw_addr, s_aw_valid, s_w_data, s_w_strb, s_w_valid, s_b_ready,
    output s_ar_addr, s_ar_valid, s_r_ready,
    input  s_aw_ready, s_w_ready, s_b_resp, s_b_valid, s_ar_ready, s_r_data, s_r_resp, s_r_valid,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/axi4l_wb_bridge_dec.sv
// AXI4-Lite slave to Wishbone B3 classic master with an N-way address decoder,
// DECERR for unmapped addresses, WB_ERR/timeout to SLVERR and read/write round-robin.
module axi4l_wb_bridge_dec #(
  parameter int                                ADDR_WIDTH = 32,
  parameter int                                DATA_WIDTH = 32,
  parameter int                                NR_SLAVES  = 3,
  parameter logic [NR_SLAVES*ADDR_WIDTH-1:0]   SLAVE_BASE = '0,
  parameter logic [NR_SLAVES*ADDR_WIDTH-1:0]   SLAVE_MASK = '0,
  parameter int                                TIMEOUT    = 255
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  axi4l_wb_bridge_dec_if.slave bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NR_SLAVES > 1) ? $clog2(NR_SLAVES) : 1;
  localparam int TMO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, WB_ACC = 2'd1, RESP = 2'd2} state_t;

  state_t                  state_q;
  logic                    run_q, last_wr_q, cur_wr_q;
  logic [IDX_W-1:0]        cur_idx_q;
  logic [TMO_W-1:0]        tmo_cnt_q;
  logic [NR_SLAVES-1:0]    cyc_q, stb_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q, r_data_q;
  logic [STRB_W-1:0]       sel_q;
  logic                    we_q, b_valid_q, r_valid_q;
  logic [1:0]              b_resp_q, r_resp_q;

  logic                    idle, wr_elig, rd_elig, grant_wr, grant_rd, hit_any;
  logic                    sel_ack, sel_err, tmo_hit, acc_ok, wb_done;
  logic [IDX_W-1:0]        hit_idx;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   sel_dat;
  logic [1:0]              done_resp;

  function automatic logic [TMO_W-1:0] tmo_inc(input logic [TMO_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // run_q keeps the readies low while reset is asserted and for the first edge after it.
  assign idle     = run_q && (state_q == IDLE);
  assign wr_elig  = bus.s_aw_valid && bus.s_w_valid;
  assign rd_elig  = bus.s_ar_valid;
  assign grant_wr = idle && wr_elig && (!rd_elig || !last_wr_q);
  assign grant_rd = idle && rd_elig && (!wr_elig || last_wr_q);
  assign acc_addr = grant_wr ? bus.s_aw_addr : bus.s_ar_addr;

  // Scan downwards so the lowest-index hit is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NR_SLAVES - 1; i >= 0; i--) begin
      if ((acc_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign sel_ack   = bus.wb_ack_i[cur_idx_q];
  assign sel_err   = bus.wb_err_i[cur_idx_q];
  assign sel_dat   = bus.wb_dat_i[int'(cur_idx_q)*DATA_WIDTH +: DATA_WIDTH];
  assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
  assign acc_ok    = sel_ack && !sel_err;
  assign wb_done   = sel_ack || sel_err || tmo_hit;
  assign done_resp = acc_ok ? RESP_OKAY : RESP_SLVERR;

  assign bus.s_aw_ready = grant_wr;
  assign bus.s_w_ready  = grant_wr;
  assign bus.s_ar_ready = grant_rd;
  assign bus.s_b_valid  = b_valid_q;
  assign bus.s_b_resp   = b_resp_q;
  assign bus.s_r_valid  = r_valid_q;
  assign bus.s_r_resp   = r_resp_q;
  assign bus.s_r_data   = r_data_q;
  assign bus.wb_adr_o   = adr_q;
  assign bus.wb_dat_o   = dat_q;
  assign bus.wb_sel_o   = sel_q;
  assign bus.wb_we_o    = we_q;
  assign bus.wb_cyc_o   = cyc_q;
  assign bus.wb_stb_o   = stb_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      run_q     <= 1'b0;
      last_wr_q <= 1'b0;
      cur_wr_q  <= 1'b0;
      cur_idx_q <= '0;
      tmo_cnt_q <= '0;
      cyc_q     <= '0;
      stb_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      b_valid_q <= 1'b0;
      b_resp_q  <= 2'b00;
      r_valid_q <= 1'b0;
      r_resp_q  <= 2'b00;
      r_data_q  <= '0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (grant_wr || grant_rd) begin
            cur_wr_q  <= grant_wr;
            tmo_cnt_q <= '0;
            if (hit_any) begin
              state_q   <= WB_ACC;
              cur_idx_q <= hit_idx;
              cyc_q     <= NR_SLAVES'(1) << hit_idx;
              stb_q     <= NR_SLAVES'(1) << hit_idx;
              adr_q     <= acc_addr;
              we_q      <= grant_wr;
              dat_q     <= grant_wr ? bus.s_w_data : '0;
              sel_q     <= grant_wr ? bus.s_w_strb : '1;
            end else begin
              // Unmapped: answer directly without touching the Wishbone side.
              state_q <= RESP;
              if (grant_wr) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= RESP_DECERR;
              end else begin
                r_valid_q <= 1'b1;
                r_resp_q  <= RESP_DECERR;
                r_data_q  <= '0;
              end
            end
          end
        end
        WB_ACC: begin
          if (wb_done) begin
            cyc_q   <= '0;
            stb_q   <= '0;
            we_q    <= 1'b0;
            state_q <= RESP;
            if (cur_wr_q) begin
              b_valid_q <= 1'b1;
              b_resp_q  <= done_resp;
            end else begin
              r_valid_q <= 1'b1;
              r_resp_q  <= done_resp;
              r_data_q  <= acc_ok ? sel_dat : '0;
            end
          end else begin
            tmo_cnt_q <= tmo_inc(tmo_cnt_q);
          end
        end
        RESP: begin
          if (cur_wr_q && b_valid_q && bus.s_b_ready) begin
            b_valid_q <= 1'b0;
            last_wr_q <= 1'b1;
            state_q   <= IDLE;
          end else if (!cur_wr_q && r_valid_q && bus.s_r_ready) begin
            r_valid_q <= 1'b0;
            last_wr_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4l_wb_bridge_dec.sv
// Self-checking bench for axi4l_wb_bridge_dec: directed and randomized AXI transactions
// against behavioural Wishbone targets and a decode/response reference model.
module tb_axi4l_wb_bridge_dec;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 3;
  localparam int TMO = 8;
  // slave0 0x1xxxxxxx, slave1 0x2xxxxxxx, slave2 0x2/0x3xxxxxxx (shadowed by slave1 in 0x2)
  localparam logic [NS*AW-1:0] BASE = {32'h2000_0000, 32'h2000_0000, 32'h1000_0000};
  localparam logic [NS*AW-1:0] MASK = {32'hE000_0000, 32'hF000_0000, 32'hF000_0000};

  logic clk, rst_n;
  axi4l_wb_bridge_dec_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_SLAVES(NS)) bus ();

  axi4l_wb_bridge_dec #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_SLAVES(NS),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(TMO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Wishbone target behaviour: mode 0 ack, 1 err, 2 never answer, 3 ack+err together.
  int          mode[NS];
  int          dly[NS];
  logic [31:0] rword[NS];
  bit          noise;
  int          cnt[NS];
  int          stb_cnt[NS];
  int          bursts[NS];
  logic [31:0] obs_adr, obs_dat;
  logic [3:0]  obs_sel;
  logic        obs_we;
  logic [NS-1:0] ack_v, err_v;

  // Reference model state
  logic [31:0] base_m[NS] = '{32'h1000_0000, 32'h2000_0000, 32'h2000_0000};
  logic [31:0] mask_m[NS] = '{32'hF000_0000, 32'hF000_0000, 32'hE000_0000};
  bit          model_last_wr;

  bit rr_mon;
  int grants[$];

  assign bus.wb_dat_i = {rword[2], rword[1], rword[0]};

  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      ack_v[i] = 1'b0;
      err_v[i] = 1'b0;
      if (bus.wb_cyc_o[i] && bus.wb_stb_o[i]) begin
        cnt[i]++;
        stb_cnt[i]++;
        if (cnt[i] == 1) bursts[i]++;
        obs_adr = bus.wb_adr_o;
        obs_dat = bus.wb_dat_o;
        obs_sel = bus.wb_sel_o;
        obs_we  = bus.wb_we_o;
        if (cnt[i] >= dly[i]) begin
          ack_v[i] = (mode[i] == 0) || (mode[i] == 3);
          err_v[i] = (mode[i] == 1) || (mode[i] == 3);
        end
      end else begin
        cnt[i]   = 0;
        ack_v[i] = noise;
      end
    end
    bus.wb_ack_i = ack_v;
    bus.wb_err_i = err_v;
  end

  always @(posedge clk) begin
    if (rr_mon) begin
      if (bus.s_aw_valid && bus.s_aw_ready) grants.push_back(1);
      else if (bus.s_ar_valid && bus.s_ar_ready) grants.push_back(0);
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: observed no finish, required finish before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] addr);
    for (int i = 0; i < NS; i++)
      if ((addr & mask_m[i]) == base_m[i]) return i;
    return -1;
  endfunction

  task automatic axi_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output logic [1:0] resp, output logic [31:0] rdata,
                         output int lat, output bit ok);
    int w;
    ok = 1'b1; lat = 0; resp = 2'b00; rdata = '0;
    @(negedge clk);
    if (is_wr) begin
      bus.s_aw_addr = addr; bus.s_w_data = data; bus.s_w_strb = strb;
      bus.s_aw_valid = 1'b1; bus.s_w_valid = 1'b1;
    end else begin
      bus.s_ar_addr = addr; bus.s_ar_valid = 1'b1;
    end
    w = 0;
    forever begin
      #1;
      if (is_wr ? bus.s_aw_ready : bus.s_ar_ready) break;
      @(negedge clk);
      w++;
      if (w > 50) begin
        chk("accept_timeout", 0, 1);
        bus.s_aw_valid = 1'b0; bus.s_w_valid = 1'b0; bus.s_ar_valid = 1'b0;
        ok = 1'b0;
        return;
      end
    end
    if (is_wr) chk("aw_w_ready_pair", bus.s_w_ready, bus.s_aw_ready);
    @(posedge clk);
    #1;
    bus.s_aw_valid = 1'b0; bus.s_w_valid = 1'b0; bus.s_ar_valid = 1'b0;
    forever begin
      @(negedge clk);
      lat++;
      if (is_wr ? bus.s_b_valid : bus.s_r_valid) break;
      if (lat > 40) begin
        chk("resp_timeout", 0, 1);
        ok = 1'b0;
        return;
      end
    end
    resp  = is_wr ? bus.s_b_resp : bus.s_r_resp;
    rdata = bus.s_r_data;
    if (is_wr) bus.s_b_ready = 1'b1; else bus.s_r_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.s_b_ready = 1'b0; bus.s_r_ready = 1'b0;
    @(negedge clk);
    chk("valid_falls", is_wr ? bus.s_b_valid : bus.s_r_valid, 1'b0);
  endtask

  task automatic run_txn(input string tag, input bit is_wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
    int tgt, exp_lat, exp_stb, lat, others;
    logic [1:0] exp_resp, resp;
    logic [31:0] exp_rd, rdata;
    bit ok;
    tgt = ref_decode(addr);
    if (tgt < 0) begin
      exp_resp = 2'b11; exp_lat = 1; exp_stb = 0; exp_rd = '0;
    end else begin
      case (mode[tgt])
        0:       begin exp_resp = 2'b00; exp_lat = dly[tgt] + 1; exp_stb = dly[tgt]; exp_rd = rword[tgt]; end
        1, 3:    begin exp_resp = 2'b10; exp_lat = dly[tgt] + 1; exp_stb = dly[tgt]; exp_rd = '0; end
        default: begin exp_resp = 2'b10; exp_lat = TMO + 1;      exp_stb = TMO;      exp_rd = '0; end
      endcase
    end
    for (int i = 0; i < NS; i++) begin stb_cnt[i] = 0; bursts[i] = 0; end
    axi_txn(is_wr, addr, data, strb, resp, rdata, lat, ok);
    if (!ok) return;
    chk({tag, "/resp"}, resp, exp_resp);
    chk({tag, "/latency"}, lat, exp_lat);
    if (!is_wr) chk({tag, "/rdata"}, rdata, exp_rd);
    others = 0;
    for (int i = 0; i < NS; i++) if (i != tgt) others += stb_cnt[i];
    chk({tag, "/other_stb"}, others, 0);
    if (tgt >= 0) begin
      chk({tag, "/bursts"}, bursts[tgt], 1);
      chk({tag, "/stb_cycles"}, stb_cnt[tgt], exp_stb);
      chk({tag, "/wb_adr"}, obs_adr, addr);
      chk({tag, "/wb_we"}, obs_we, is_wr);
      chk({tag, "/wb_sel"}, obs_sel, is_wr ? strb : 4'hF);
      if (is_wr) chk({tag, "/wb_dat"}, obs_dat, data);
    end
    model_last_wr = is_wr;
  endtask

  initial begin
    logic [31:0] addr, data;
    logic [1:0]  resp0;
    bit          first, stable, no_acc, is_wr;
    int          t, r, w;

    for (int i = 0; i < NS; i++) begin mode[i] = 0; dly[i] = 1; rword[i] = '0; cnt[i] = 0; end
    noise = 1'b0; rr_mon = 1'b0;
    bus.s_aw_addr = 32'h2000_0000; bus.s_w_data = '0; bus.s_w_strb = 4'hF;
    bus.s_ar_addr = 32'h1000_0000; bus.s_b_ready = 1'b0; bus.s_r_ready = 1'b0;
    bus.wb_ack_i = '0; bus.wb_err_i = '0;
    // Valids high during reset: readies must still be held low.
    bus.s_aw_valid = 1'b1; bus.s_w_valid = 1'b1; bus.s_ar_valid = 1'b1;
    rst_n = 1'b0;
    #22;
    chk("rst/aw_ready", bus.s_aw_ready, 1'b0);
    chk("rst/ar_ready", bus.s_ar_ready, 1'b0);
    chk("rst/w_ready",  bus.s_w_ready, 1'b0);
    chk("rst/valids",   {bus.s_b_valid, bus.s_r_valid}, 2'b00);
    chk("rst/resps",    {bus.s_b_resp, bus.s_r_resp}, 4'h0);
    chk("rst/r_data",   bus.s_r_data, 32'h0);
    chk("rst/cyc_stb",  {bus.wb_cyc_o, bus.wb_stb_o}, 6'h0);
    chk("rst/wb_regs",  {bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, bus.wb_we_o}, 69'h0);
    bus.s_aw_valid = 1'b0; bus.s_w_valid = 1'b0; bus.s_ar_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_last_wr = 1'b0;
    repeat (2) @(negedge clk);

    // Directed scenarios
    mode[1] = 0; dly[1] = 2;
    run_txn("wr_s1", 1'b1, 32'h2000_0000, 32'hDEAD_BEEF, 4'hF);
    mode[0] = 0; dly[0] = 1; rword[0] = 32'h1234_5678;
    run_txn("rd_s0", 1'b0, 32'h1000_0004, 32'h0, 4'h0);
    run_txn("rd_unmapped", 1'b0, 32'h5000_0000, 32'h0, 4'h0);
    run_txn("wr_unmapped", 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'h3);
    mode[2] = 1; dly[2] = 2;
    run_txn("wr_s2_err", 1'b1, 32'h3000_0010, 32'h0BAD_0BAD, 4'h5);
    mode[2] = 2;
    run_txn("wr_s2_tmo", 1'b1, 32'h3000_0020, 32'h1111_2222, 4'hF);
    mode[0] = 3; dly[0] = 3; rword[0] = 32'hA5A5_5A5A;
    run_txn("rd_s0_ackerr", 1'b0, 32'h1000_0008, 32'h0, 4'h0);
    mode[2] = 0; dly[2] = 1; rword[2] = 32'h7777_0002;
    run_txn("rd_s2_region", 1'b0, 32'h3000_0000, 32'h0, 4'h0);

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      is_wr = 1'($urandom_range(0, 1));
      t = $urandom_range(0, 3);
      case (t)
        0:       addr = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
        1:       addr = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
        2:       addr = 32'h3000_0000 | ($urandom & 32'h0FFF_FFFC);
        default: addr = 32'h4000_0000 | ($urandom & 32'h3FFF_FFFC);
      endcase
      if (t < 3) begin
        r = $urandom_range(0, 9);
        mode[t]  = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 3 : 2;
        dly[t]   = $urandom_range(1, 4);
        rword[t] = $urandom;
      end
      noise = 1'($urandom_range(0, 1));
      data  = $urandom;
      run_txn($sformatf("rand%0d", n), is_wr, addr, data, 4'($urandom_range(0, 15)));
    end
    noise = 1'b0;

    // Round-robin with every channel continuously valid
    mode[0] = 0; dly[0] = 1; mode[1] = 0; dly[1] = 1;
    first = !model_last_wr;
    grants.delete();
    @(negedge clk);
    bus.s_aw_addr = 32'h2000_0040; bus.s_w_data = 32'h5555_AAAA; bus.s_w_strb = 4'hF;
    bus.s_ar_addr = 32'h1000_0040;
    bus.s_b_ready = 1'b1; bus.s_r_ready = 1'b1;
    rr_mon = 1'b1;
    bus.s_aw_valid = 1'b1; bus.s_w_valid = 1'b1; bus.s_ar_valid = 1'b1;
    w = 0;
    while (grants.size() < 4 && w < 200) begin @(negedge clk); w++; end
    bus.s_aw_valid = 1'b0; bus.s_w_valid = 1'b0; bus.s_ar_valid = 1'b0;
    repeat (10) @(negedge clk);
    rr_mon = 1'b0;
    bus.s_b_ready = 1'b0; bus.s_r_ready = 1'b0;
    chk("rr/grant_count", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      chk($sformatf("rr/grant%0d", k), grants[k], (k % 2 == 0) ? first : !first);
    if (grants.size() > 0) model_last_wr = grants[grants.size() - 1] != 0;

    // B channel back-pressure
    mode[1] = 0; dly[1] = 1;
    @(negedge clk);
    bus.s_aw_addr = 32'h2000_0080; bus.s_w_data = 32'h0F0F_0F0F; bus.s_w_strb = 4'hF;
    bus.s_aw_valid = 1'b1; bus.s_w_valid = 1'b1;
    w = 0;
    forever begin #1; if (bus.s_aw_ready || w > 50) break; @(negedge clk); w++; end
    @(posedge clk);
    #1;
    bus.s_aw_valid = 1'b0; bus.s_w_valid = 1'b0;
    w = 0;
    forever begin @(negedge clk); w++; if (bus.s_b_valid || w > 40) break; end
    chk("stall/b_valid_seen", bus.s_b_valid, 1'b1);
    resp0 = bus.s_b_resp;
    bus.s_ar_addr = 32'h1000_0000; bus.s_ar_valid = 1'b1;
    stable = 1'b1; no_acc = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (!bus.s_b_valid || bus.s_b_resp !== resp0) stable = 1'b0;
      if (bus.s_ar_ready || bus.s_aw_ready) no_acc = 1'b0;
    end
    chk("stall/b_stable", stable, 1'b1);
    chk("stall/no_accept", no_acc, 1'b1);
    chk("stall/b_resp", resp0, 2'b00);
    bus.s_ar_valid = 1'b0;
    bus.s_b_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.s_b_ready = 1'b0;
    @(negedge clk);
    chk("stall/b_valid_falls", bus.s_b_valid, 1'b0);
    model_last_wr = 1'b1;

    // Asynchronous reset in the middle of a Wishbone cycle
    mode[2] = 2;
    @(negedge clk);
    bus.s_aw_addr = 32'h3000_0100; bus.s_w_data = 32'h9999_8888;
    bus.s_aw_valid = 1'b1; bus.s_w_valid = 1'b1;
    w = 0;
    forever begin #1; if (bus.s_aw_ready || w > 50) break; @(negedge clk); w++; end
    @(posedge clk);
    #1;
    bus.s_aw_valid = 1'b0; bus.s_w_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst/stb_before", bus.wb_stb_o, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst/cyc", bus.wb_cyc_o, 3'b000);
    chk("arst/stb", bus.wb_stb_o, 3'b000);
    chk("arst/valids", {bus.s_b_valid, bus.s_r_valid}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_last_wr = 1'b0;
    mode[2] = 0;
    repeat (3) @(negedge clk);
    chk("arst/no_b_after", bus.s_b_valid, 1'b0);
    mode[0] = 0; dly[0] = 2; rword[0] = 32'h0C0F_FEE0;
    run_txn("post_rst_rd", 1'b0, 32'h1000_0010, 32'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
